// File: rtl/controle_divisor.sv
// ---------------------------------------------------------------------------
// controle_divisor
//
// Sequential unsigned restoring divider. A single compare/subtract stage is
// reused over WIDTH clock cycles, so one quotient bit is produced per cycle.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, aborts any running division
//   Start        request, accepted only in IDLE or DONE
//   A, B         dividend and divisor, captured when Start is accepted
//   Busy         high while iterating (state CALC)
//   Done         one-cycle pulse, S / Resto_final / Div0 are valid
//   S            quotient (registered)
//   Resto_final  remainder (registered)
//   Div0         registered, set when the captured divisor was zero
//
// Timing: with Start accepted at edge t, a non-zero divisor gives Busy in
// cycles t+1..t+WIDTH and Done in cycle t+WIDTH+1. A zero divisor skips the
// iteration and gives Done in cycle t+1.
// ---------------------------------------------------------------------------
module controle_divisor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Resto_final,
   output logic             Div0
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Dividend and quotient share one shift register: each cycle the dividend
   // MSB leaves at the top while the new quotient bit enters at the bottom.
   // After WIDTH shifts the register holds the complete quotient.
   logic [WIDTH-1:0] shift_reg,   shift_next;
   logic [WIDTH-1:0] divisor_reg, divisor_next;
   // The partial remainder is always strictly below the divisor, so WIDTH
   // bits hold it exactly; only the shifted value P needs the extra bit.
   logic [WIDTH-1:0] rem_reg,     rem_next;
   logic [CW-1:0]    count_reg,   count_next;
   logic [WIDTH-1:0] s_reg,       s_next;
   logic [WIDTH-1:0] resto_reg,   resto_next;
   logic             div0_reg,    div0_next;

   // Single reusable compare/subtract stage
   logic [WIDTH:0]   partial;
   logic             take;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quot_step;

   always_comb begin
      // P = {R, dividend MSB}; the (WIDTH+1)-bit width keeps the top bit when
      // the divisor is larger than 2^(WIDTH-1).
      partial   = {rem_reg, shift_reg[WIDTH-1]};
      take      = (partial >= {1'b0, divisor_reg});
      // When take is set the true difference is below the divisor, so the
      // upper bit of the subtraction is always zero and can be dropped.
      diff      = partial[WIDTH-1:0] - divisor_reg;
      rem_step  = take ? diff : partial[WIDTH-1:0];
      quot_step = {shift_reg[WIDTH-2:0], take};
   end

   // -----------------------------------------------------------------------
   // State register and datapath registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         divisor_reg <= '0;
         rem_reg     <= '0;
         count_reg   <= '0;
         s_reg       <= '0;
         resto_reg   <= '0;
         div0_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         divisor_reg <= divisor_next;
         rem_reg     <= rem_next;
         count_reg   <= count_next;
         s_reg       <= s_next;
         resto_reg   <= resto_next;
         div0_reg    <= div0_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and datapath control
   // -----------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      divisor_next = divisor_reg;
      rem_next     = rem_reg;
      count_next   = count_reg;
      s_next       = s_reg;
      resto_next   = resto_reg;
      div0_next    = div0_reg;

      unique case (state_reg)
         IDLE, DONE: begin
            // DONE accepts Start exactly like IDLE so operations can run
            // back-to-back without an idle cycle in between.
            if (Start) begin
               if (B == '0) begin
                  // Divide by zero: report immediately, no iteration.
                  state_next = DONE;
                  s_next     = '0;
                  resto_next = A;
                  div0_next  = 1'b1;
               end else begin
                  state_next   = CALC;
                  shift_next   = A;
                  divisor_next = B;
                  rem_next     = '0;
                  count_next   = CW'(WIDTH - 1);
                  div0_next    = 1'b0;
               end
            end else begin
               state_next = IDLE;
            end
         end

         CALC: begin
            // Start is deliberately not looked at here: the captured
            // operands stay untouched until the division completes.
            shift_next = quot_step;
            rem_next   = rem_step;
            if (count_reg == '0) begin
               // Last bit: publish results on the edge entering DONE.
               state_next = DONE;
               s_next     = quot_step;
               resto_next = rem_step;
            end else begin
               count_next = count_reg - 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign Busy        = (state_reg == CALC);
   assign Done        = (state_reg == DONE);
   assign S           = s_reg;
   assign Resto_final = resto_reg;
   assign Div0        = div0_reg;

endmodule

// File: tb/tb_controle_divisor.sv
// ---------------------------------------------------------------------------
// tb_controle_divisor
//
// Directed and random checks for controle_divisor (WIDTH = 8): reset state,
// latency and Busy length, quotient/remainder values, divide by zero, Start
// ignored during iteration, reset abort and back-to-back operation.
// ---------------------------------------------------------------------------
module tb_controle_divisor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] Resto_final;
   logic             Div0;

   int checks   = 0;
   int failures = 0;

   controle_divisor #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .Start       (Start),
      .A           (A),
      .B           (B),
      .Busy        (Busy),
      .Done        (Done),
      .S           (S),
      .Resto_final (Resto_final),
      .Div0        (Div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issues one operation starting at a negedge and returns at the negedge of
   // the Done cycle. inject_at > 0 pulses Start (A=9, B=9) in that cycle.
   task automatic do_op(input string tag, input int a, input int b,
                        input int es, input int er, input int ed, input int inject_at);
      int lat;
      int busy_cnt;
      int s_hold;
      int r_hold;
      int exp_lat;
      s_hold   = S;
      r_hold   = Resto_final;
      lat      = 0;
      busy_cnt = 0;
      Start = 1'b1;
      A     = WIDTH'(a);
      B     = WIDTH'(b);
      @(posedge clk);
      #1;
      // Scramble operands to confirm they were captured.
      Start = 1'b0;
      A     = WIDTH'($urandom);
      B     = WIDTH'($urandom);
      forever begin
         @(negedge clk);
         lat++;
         if (inject_at != 0 && lat == inject_at) begin
            Start = 1'b1;
            A     = 8'd9;
            B     = 8'd9;
         end else if (inject_at != 0 && lat == inject_at + 1) begin
            Start = 1'b0;
         end
         if (Busy) busy_cnt++;
         if (lat == 4 && b != 0) begin
            check({tag, "_S_hold"}, S, s_hold);
            check({tag, "_R_hold"}, Resto_final, r_hold);
         end
         if (Done) break;
         if (lat > 40) begin
            check({tag, "_timeout"}, lat, 0);
            break;
         end
      end
      exp_lat = (b == 0) ? 1 : WIDTH + 1;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy"}, busy_cnt, (b == 0) ? 0 : WIDTH);
      check({tag, "_S"}, S, es);
      check({tag, "_R"}, Resto_final, er);
      check({tag, "_Div0"}, Div0, ed);
      $display("op %s A=%0d B=%0d -> S=%0d R=%0d Div0=%0d latency=%0d",
               tag, a, b, S, Resto_final, Div0, lat);
   endtask

   initial begin
      int done_seen;
      int a;
      int b;
      rst   = 1'b1;
      Start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_Busy", Busy, 0);
      check("rst_Done", Done, 0);
      check("rst_S", S, 0);
      check("rst_R", Resto_final, 0);
      check("rst_Div0", Div0, 0);

      // 1. Basic division
      do_op("t1_200_7", 200, 7, 28, 4, 0, 0);
      @(negedge clk);
      check("t1_done_pulse", Done, 0);

      // 2. Divisor MSB set, equal operands, dividend < divisor
      do_op("t2_250_200", 250, 200, 1, 50, 0, 0);
      @(negedge clk);
      do_op("t2_255_255", 255, 255, 1, 0, 0, 0);
      @(negedge clk);
      do_op("t2_5_9", 5, 9, 0, 5, 0, 0);
      @(negedge clk);

      // 3. Divide by zero
      do_op("t3_13_0", 13, 0, 0, 13, 1, 0);
      @(negedge clk);

      // 4. Start during CALC is ignored
      do_op("t4_100_3", 100, 3, 33, 1, 0, 3);
      @(negedge clk);
      check("t4_after_Busy", Busy, 0);
      check("t4_after_Done", Done, 0);

      // 5. Reset in the middle of CALC
      Start = 1'b1;
      A     = 8'd200;
      B     = 8'd7;
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_Busy", Busy, 0);
      check("t5_Done", Done, 0);
      check("t5_S", S, 0);
      check("t5_R", Resto_final, 0);
      check("t5_Div0", Div0, 0);
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (Done) done_seen++;
      end
      check("t5_no_done", done_seen, 0);
      do_op("t5_after", 200, 7, 28, 4, 0, 0);
      @(negedge clk);

      // 6. Back-to-back: second Start presented in the Done cycle
      do_op("t6_first", 100, 7, 14, 2, 0, 0);
      do_op("t6_64_8", 64, 8, 8, 0, 0, 0);
      @(negedge clk);

      // Random sweep against the arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         a = $urandom_range(0, 255);
         b = (i % 50 == 0) ? 0 : $urandom_range(0, 255);
         if (b == 0)
            do_op("rand", a, b, 0, a, 1, 0);
         else
            do_op("rand", a, b, a / b, a % b, 0, 0);
         if (i % 2 == 0) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL global_timeout observed=1 expected=0");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/controle_divisor.md
Name: controle_divisor

Overview:
Sequential restoring divider controller that replaces the fully unrolled 8-stage combinational array with one subtract/compare stage reused over WIDTH clock cycles.
- Accepts a Start pulse with dividend A and divisor B.
- Iterates one quotient bit per cycle and presents quotient, remainder and divide-by-zero flag with a one-cycle Done pulse.
- Sits between the control unit and the arithmetic datapath, trading latency for area.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (≥2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
Start  input  1  request; sampled when controller is idle or in DONE
A  input  WIDTH  dividend, captured on accepted Start
B  input  WIDTH  divisor, captured on accepted Start
Busy  output  1  high while iterating (state CALC)
Done  output  1  one-cycle pulse: results valid
S  output  WIDTH  quotient, registered
Resto_final  output  WIDTH  remainder, registered
Div0  output  1  registered; 1 when captured B was zero

Behaviour:
- Reset (rst=1 at a rising edge):
  - state→IDLE; Busy=0, Done=0, S=0, Resto_final=0, Div0=0.
  - Internal registers cleared.
  - Reset mid-CALC aborts the operation; no Done is produced.
- States:
  - IDLE: Busy=0, Done=0.
    - Start=1 and B≠0 → CALC.
    - Start=1 and B=0 → DONE with S=0, Resto_final=A, Div0=1.
  - CALC: Busy=1.
    - On entry: dividend shift register=A, divisor register=B, partial remainder R=0 (WIDTH+1 bits), counter=WIDTH-1, Div0=0.
    - Each cycle: P={R[WIDTH-1:0], dividend MSB}, WIDTH+1 bits, so no MSB loss when B>2^(WIDTH-1).
    - If P≥B: quotient bit=1, R=P-B. Otherwise quotient bit=0, R=P.
    - Quotient bit shifts into the LSB of the quotient register; dividend shifts left.
    - Counter==0 → DONE. Otherwise decrement.
  - DONE: Done=1 for exactly this cycle, Busy=0.
    - S, Resto_final and Div0 update on the edge entering DONE and hold until the next accepted Start's results overwrite them.
    - Start=1 → accepted exactly as in IDLE (back-to-back operation). Otherwise → IDLE.
- Latency: Start sampled at edge t.
  - B≠0: Busy high for cycles t+1..t+WIDTH; Done high in cycle t+WIDTH+1.
  - B=0: Done high in cycle t+1.
- Start while in CALC is ignored; captured operands are unaffected by changes on A and B.
- Arithmetic: unsigned only. Invariant A = S·B + Resto_final with Resto_final < B whenever Div0=0.
- Outputs S and Resto_final do not change during CALC; they show the previous results until DONE.

Test Plan:
1. Reset, then Start with A=200, B=7 → Busy high 8 cycles; Done pulses in cycle t+9 with S=28, Resto_final=4, Div0=0.
2. A=250, B=200 (MSB path) → S=1, Resto_final=50; A=255, B=255 → S=1, Resto_final=0; A=5, B=9 → S=0, Resto_final=5.
3. A=13, B=0 → Done in cycle t+1, Div0=1, S=0, Resto_final=13, Busy never asserted.
4. Start A=100, B=3; pulse Start with A=9, B=9 at cycle t+3 → second Start ignored; Done at t+9 with S=33, Resto_final=1.
5. Start A=200, B=7; assert rst at cycle t+4 → all outputs 0 next cycle, no Done pulse, state IDLE; a new Start afterwards yields a correct result.
6. Back-to-back: Start held high in the DONE cycle with A=64, B=8 → second Done exactly 9 cycles later with S=8, Resto_final=0. Finish with a random sweep of 1000 operand pairs checked against a reference model.
